// File: rtl/hwpe_stream_package.sv
// hwpe_stream_package: shared types for the hwpe stream network.
// Holds the occupancy flag bundle used by zero-network comparators.
package hwpe_stream_package;

  typedef struct packed {
    logic        empty;
    logic        full;
    logic [31:0] count;
  } flags_zero_fifo_t;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// hwpe_stream_intf_stream: valid/ready stream with data and byte strobe.
// Sink and source modports give the two ends of one link.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (
    output valid,
    output data,
    output strb,
    input  ready
  );

  modport sink (
    input  valid,
    input  data,
    input  strb,
    output ready
  );

endinterface

// File: rtl/hwpe_stream_zero_fifo.sv
// hwpe_stream_zero_fifo: strb-only shadow FIFO for the zero network.
// Mirrors a normal hwpe_stream_fifo's handshakes; data is never stored.
module hwpe_stream_zero_fifo
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  hwpe_stream_intf_stream.sink   push_i,
  hwpe_stream_intf_stream.source pop_o,
  output logic empty_o,
  output logic full_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

  logic [STRB_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              empty;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH);
  assign do_push = push_i.valid & ~full;
  assign do_pop  = pop_o.ready & ~empty;

  assign push_i.ready = ~full;
  assign pop_o.valid  = ~empty;
  assign pop_o.strb   = empty ? '0 : mem_q[rd_ptr_q];

  assign empty_o = empty;
  assign full_o  = full;
  assign count_o = count_q;

  // Next pointers wrap at FIFO_DEPTH-1 so any depth >= 2 works.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state; clear wins over push and pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Strobe storage; a flush leaves stale entries behind harmlessly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_i.strb;
    end
  end

endmodule

// File: doc/hwpe_stream_zero_fifo.md
Name: hwpe_stream_zero_fifo

Overview:
- Strobe-only FIFO for the zero (shadow) stream network used for low-area fault detection.
- Sits directly downstream of hwpe_stream_zero_source. It mirrors a normal hwpe_stream_fifo instance in the functional path, so that the zero network matches the original network cycle for cycle.
- Buffers only valid/strb handshake information. Data is never stored or driven, so synthesis can drop it.
- Exposes occupancy flags so the comparison logic can detect divergence from the normal FIFO.

Parameters:
- DATA_WIDTH, 32, data width of the attached interfaces; sets strb width DATA_WIDTH/8. No data storage is built.
- FIFO_DEPTH, 8, number of entries; legal values are >= 2, and non-power-of-two depths are allowed.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- clear_i  input  1  synchronous flush, active-high
- push_i  hwpe_stream_intf_stream.sink  DATA_WIDTH/8 strb  incoming zero stream (from hwpe_stream_zero_source.zero_o)
- pop_o  hwpe_stream_intf_stream.source  DATA_WIDTH/8 strb  outgoing zero stream
- empty_o  output  1  FIFO holds 0 entries
- full_o  output  1  FIFO holds FIFO_DEPTH entries
- count_o  output  $clog2(FIFO_DEPTH+1)  current occupancy

Behaviour:
- Reset (rst_ni low, asynchronous):
  - wr_ptr, rd_ptr and count go to 0; all strb entries go to '0.
  - Outputs: empty_o=1, full_o=0, count_o=0, pop_o.valid=0, pop_o.strb='0, push_i.ready=1.
  - Reset applied mid-operation discards all contents immediately.
- Handshake rules:
  - push_i.ready = !full. A push occurs when push_i.valid & push_i.ready.
  - pop_o.valid = !empty. A pop occurs when pop_o.valid & pop_o.ready.
- Data handling:
  - pop_o.strb = entry at rd_ptr when non-empty, '0 when empty.
  - pop_o.data is never assigned. push_i.data is ignored.
- Latency: registered and not fall-through. An entry pushed in cycle N is visible at pop_o in cycle N+1 at the earliest.
- Per clock edge:
  - On a push, write push_i.strb to entry wr_ptr and advance wr_ptr.
  - On a pop, advance rd_ptr.
  - count += push - pop.
- Pointer wrap: pointers increment modulo FIFO_DEPTH; index FIFO_DEPTH-1 wraps to 0.
- Simultaneous push and pop:
  - Legal when 0 < count < FIFO_DEPTH; count is unchanged and both pointers advance.
  - When full, push_i.ready=0, so only a pop can occur.
  - When empty, pop_o.valid=0, so only a push can occur. There is no bypass.
- Flag derivation: empty_o = (count==0) and full_o = (count==FIFO_DEPTH), both derived combinationally from registered count.
- clear_i:
  - Behaves as a synchronous reset of pointers and count on the next edge.
  - Overrides any push or pop in the same cycle.
  - Storage contents need not be cleared.
- Valid/strb stability: pop_o.valid and pop_o.strb hold stable while pop_o.valid & !pop_o.ready.
- Handshake timing must equal hwpe_stream_fifo (non-latch variant) with the same depth. Any ready/valid mismatch between the two is a fault by construction.

Decomposition:
- Flags struct flags_zero_fifo_t {empty, full, count} is added to hwpe_stream_package for reuse by zero-network comparators.
- No new constants are needed.
- Single flat module. Pointer/counter logic is small enough that no sub-module is warranted.

Test Plan:
All cases use DATA_WIDTH=32, FIFO_DEPTH=4.
- Reset mid-stream: push 3 entries, assert rst_ni low for 1 cycle -> immediately empty_o=1, count_o=0, pop_o.valid=0, push_i.ready=1.
- Fill/empty:
  - Push strb 4'h1,4'h3,4'h7,4'hF with pop_o.ready=0 -> full_o=1, push_i.ready=0, count_o=4.
  - Then pop 4 times -> strb out in order 1,3,7,F; empty_o=1 after the last pop.
- Latency: push 4'hA in cycle N into an empty FIFO -> pop_o.valid=0 in cycle N, 1 with strb 4'hA in cycle N+1.
- Simultaneous push/pop:
  - At count=2, push and pop each cycle for 10 cycles -> count_o stays 2.
  - Pointers wrap past 3; strb order is preserved.
- Full boundary: at count=4 with push_i.valid=1 and pop_o.ready=1 -> exactly one pop, no push; count_o=3 next cycle.
- clear_i: at count=3, assert clear_i together with a push and a pop -> next cycle count_o=0 and empty_o=1; the pushed entry is not visible.
- Lockstep check: drive hwpe_stream_fifo and this block with identical handshakes for 1000 random cycles -> ready/valid identical every cycle.
